robot_cmd_scheduler: RTL and testbench

Command scheduler between the pipe-cleaning robot's decision FSM and its physical actuators. It samples the FSM's one-hot command outputs (front/turn/remove) and runs each command on the drive, rotation or brush actuator for a fixed number of cycles. It then emits a one-cycle `step` strobe that the FSM uses as its state-register enable. It also supervises the command stream: it counts forward moves, detects a robot spinning in place or stuck on trash, and flags malformed commands.

---
 rtl/robot_sched_pkg.sv | 29 ++
 rtl/robot_sched_timer.sv | 31 +++
 rtl/robot_cmd_scheduler.sv | 244 ++++++++++++++++++++++++
 tb/tb_robot_cmd_scheduler.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/robot_sched_pkg.sv
// Shared types and constants for the pipe-cleaning robot command scheduler.
package robot_sched_pkg;

    typedef enum logic [2:0] {
        ST_SAMPLE     = 3'd0,
        ST_RUN_FRONT  = 3'd1,
        ST_RUN_TURN   = 3'd2,
        ST_RUN_REMOVE = 3'd3,
        ST_SETTLE     = 3'd4,
        ST_DONE       = 3'd5,
        ST_FAULT      = 3'd6
    } sched_state_t;

    localparam logic [1:0] FLT_NONE  = 2'b00;
    localparam logic [1:0] FLT_SPIN  = 2'b01;
    localparam logic [1:0] FLT_TRASH = 2'b10;
    localparam logic [1:0] FLT_CMD   = 2'b11;

    // True when two or more of the three command bits are set.
    function automatic logic is_multi_hot(input logic [2:0] cmd);
        return (cmd[0] & cmd[1]) | (cmd[0] & cmd[2]) | (cmd[1] & cmd[2]);
    endfunction

    // Bits needed to hold every value in 0..max_val (never less than 1).
    function automatic int width_for(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/robot_sched_timer.sv
// Loadable down-counter timing how long an actuator stays enabled.
// It stops at zero rather than wrapping, so it is harmless if left enabled.
module robot_sched_timer #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] count_r;

    // Load a new duration, otherwise count down while enabled until zero.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_r <= {W{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (en && (count_r != {W{1'b0}})) begin
            count_r <= count_r - {{(W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign zero = (count_r == {W{1'b0}});

endmodule

// File: rtl/robot_cmd_scheduler.sv
// Runs the decision FSM's one-hot commands on the actuators for fixed
// durations, returns a step strobe, and supervises the command stream.
module robot_cmd_scheduler
    import robot_sched_pkg::*;
#(
    parameter int FRONT_CYCLES  = 8,
    parameter int TURN_CYCLES   = 4,
    parameter int REMOVE_CYCLES = 12,
    parameter int MAX_TURNS     = 4,
    parameter int MAX_REMOVES   = 3,
    parameter int IDLE_LIMIT    = 16,
    parameter int CNT_W         = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             front,
    input  logic             turn,
    input  logic             remove,
    output logic             step,
    output logic             motor_fwd,
    output logic             motor_rot,
    output logic             brush_on,
    output logic             busy,
    output logic             done,
    output logic             fault,
    output logic [1:0]       fault_code,
    output logic [CNT_W-1:0] move_count
);

    localparam int MAXC_0 = (FRONT_CYCLES > TURN_CYCLES) ? FRONT_CYCLES : TURN_CYCLES;
    localparam int MAXC   = (MAXC_0 > REMOVE_CYCLES) ? MAXC_0 : REMOVE_CYCLES;
    localparam int TW     = width_for(MAXC - 1);
    localparam int TRN_W  = width_for(MAX_TURNS);
    localparam int REM_W  = width_for(MAX_REMOVES);
    localparam int IDL_W  = width_for(IDLE_LIMIT);

    localparam logic [TW-1:0]    FRONT_LOAD = TW'(FRONT_CYCLES - 1);
    localparam logic [TW-1:0]    TURN_LOAD  = TW'(TURN_CYCLES - 1);
    localparam logic [TW-1:0]    REM_LOAD   = TW'(REMOVE_CYCLES - 1);
    localparam logic [TRN_W-1:0] TRN_LIM    = TRN_W'(MAX_TURNS);
    localparam logic [REM_W-1:0] REM_LIM    = REM_W'(MAX_REMOVES);
    localparam logic [IDL_W-1:0] IDL_LIM    = IDL_W'(IDLE_LIMIT);

    sched_state_t     state_r;
    logic [TRN_W-1:0] consec_turns_r;
    logic [REM_W-1:0] consec_removes_r;
    logic [IDL_W-1:0] idle_cnt_r;
    logic             last_front_r;
    logic             step_r;
    logic             motor_fwd_r;
    logic             motor_rot_r;
    logic             brush_on_r;
    logic             busy_r;
    logic             done_r;
    logic             fault_r;
    logic [1:0]       fault_code_r;
    logic [CNT_W-1:0] move_count_r;

    logic [2:0]       cmd_s;
    logic             acc_front_s;
    logic             acc_turn_s;
    logic             acc_rem_s;
    logic             idle_step_s;
    logic             go_done_s;
    logic             go_fault_s;
    logic [1:0]       fault_nxt_s;
    logic [TW-1:0]    load_val_s;
    logic             run_s;
    logic             timer_zero_s;

    assign cmd_s = {front, turn, remove};

    // Decode the command sample. A limit is checked against the count
    // already reached, so the offending sample itself never issues a step.
    always_comb begin
        acc_front_s = 1'b0;
        acc_turn_s  = 1'b0;
        acc_rem_s   = 1'b0;
        idle_step_s = 1'b0;
        go_done_s   = 1'b0;
        go_fault_s  = 1'b0;
        fault_nxt_s = FLT_NONE;
        if (state_r == ST_SAMPLE) begin
            if (is_multi_hot(cmd_s)) begin
                go_fault_s  = 1'b1;
                fault_nxt_s = FLT_CMD;
            end else if (cmd_s == 3'b000) begin
                if (idle_cnt_r == IDL_LIM) begin
                    go_done_s = 1'b1;
                end else begin
                    idle_step_s = 1'b1;
                end
            end else if (turn) begin
                if (consec_turns_r == TRN_LIM) begin
                    go_fault_s  = 1'b1;
                    fault_nxt_s = FLT_SPIN;
                end else begin
                    acc_turn_s = 1'b1;
                end
            end else if (remove) begin
                if (consec_removes_r == REM_LIM) begin
                    go_fault_s  = 1'b1;
                    fault_nxt_s = FLT_TRASH;
                end else begin
                    acc_rem_s = 1'b1;
                end
            end else begin
                acc_front_s = 1'b1;
            end
        end else begin
            acc_front_s = 1'b0;
        end
    end

    // Select the duration matching the accepted command.
    always_comb begin
        load_val_s = FRONT_LOAD;
        if (acc_turn_s) begin
            load_val_s = TURN_LOAD;
        end else if (acc_rem_s) begin
            load_val_s = REM_LOAD;
        end else begin
            load_val_s = FRONT_LOAD;
        end
    end

    assign run_s = (state_r == ST_RUN_FRONT) || (state_r == ST_RUN_TURN) ||
                   (state_r == ST_RUN_REMOVE);

    robot_sched_timer #(
        .W (TW)
    ) u_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (acc_front_s | acc_turn_s | acc_rem_s),
        .load_val (load_val_s),
        .en       (run_s),
        .zero     (timer_zero_s)
    );

    // Scheduler FSM with its registered outputs and supervision counters.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r          <= ST_SAMPLE;
            consec_turns_r   <= {TRN_W{1'b0}};
            consec_removes_r <= {REM_W{1'b0}};
            idle_cnt_r       <= {IDL_W{1'b0}};
            last_front_r     <= 1'b0;
            step_r           <= 1'b0;
            motor_fwd_r      <= 1'b0;
            motor_rot_r      <= 1'b0;
            brush_on_r       <= 1'b0;
            busy_r           <= 1'b0;
            done_r           <= 1'b0;
            fault_r          <= 1'b0;
            fault_code_r     <= FLT_NONE;
            move_count_r     <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_SAMPLE: begin
                    if (go_fault_s) begin
                        state_r      <= ST_FAULT;
                        fault_r      <= 1'b1;
                        fault_code_r <= fault_nxt_s;
                    end else if (go_done_s) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                    end else if (acc_front_s) begin
                        state_r          <= ST_RUN_FRONT;
                        motor_fwd_r      <= 1'b1;
                        busy_r           <= 1'b1;
                        idle_cnt_r       <= {IDL_W{1'b0}};
                        consec_turns_r   <= {TRN_W{1'b0}};
                        consec_removes_r <= {REM_W{1'b0}};
                        last_front_r     <= 1'b1;
                    end else if (acc_turn_s) begin
                        state_r          <= ST_RUN_TURN;
                        motor_rot_r      <= 1'b1;
                        busy_r           <= 1'b1;
                        idle_cnt_r       <= {IDL_W{1'b0}};
                        consec_turns_r   <= consec_turns_r + TRN_W'(1);
                        consec_removes_r <= {REM_W{1'b0}};
                        last_front_r     <= 1'b0;
                    end else if (acc_rem_s) begin
                        state_r          <= ST_RUN_REMOVE;
                        brush_on_r       <= 1'b1;
                        busy_r           <= 1'b1;
                        idle_cnt_r       <= {IDL_W{1'b0}};
                        consec_removes_r <= consec_removes_r + REM_W'(1);
                        last_front_r     <= 1'b0;
                    end else if (idle_step_s) begin
                        idle_cnt_r <= idle_cnt_r + IDL_W'(1);
                    end else begin
                        state_r <= ST_SAMPLE;
                    end
                end
                ST_RUN_FRONT, ST_RUN_TURN, ST_RUN_REMOVE: begin
                    if (timer_zero_s) begin
                        state_r     <= ST_SETTLE;
                        motor_fwd_r <= 1'b0;
                        motor_rot_r <= 1'b0;
                        brush_on_r  <= 1'b0;
                        step_r      <= 1'b1;
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_SETTLE: begin
                    state_r <= ST_SAMPLE;
                    step_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    if (last_front_r && (move_count_r != {CNT_W{1'b1}})) begin
                        move_count_r <= move_count_r + CNT_W'(1);
                    end else begin
                        move_count_r <= move_count_r;
                    end
                end
                ST_DONE, ST_FAULT: begin
                    state_r <= state_r;
                end
                default: begin
                    state_r     <= ST_SAMPLE;
                    step_r      <= 1'b0;
                    motor_fwd_r <= 1'b0;
                    motor_rot_r <= 1'b0;
                    brush_on_r  <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    // The idle step is a live decode; hold it low while reset is asserted.
    assign step       = step_r | (idle_step_s & reset);
    assign motor_fwd  = motor_fwd_r;
    assign motor_rot  = motor_rot_r;
    assign brush_on   = brush_on_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign fault      = fault_r;
    assign fault_code = fault_code_r;
    assign move_count = move_count_r;

endmodule

// File: tb/tb_robot_cmd_scheduler.sv
// Directed self-checking bench for robot_cmd_scheduler.
module tb_robot_cmd_scheduler;

    logic        clock;
    logic        reset;
    logic        front;
    logic        turn;
    logic        remove;
    logic        step;
    logic        motor_fwd;
    logic        motor_rot;
    logic        brush_on;
    logic        busy;
    logic        done;
    logic        fault;
    logic [1:0]  fault_code;
    logic [15:0] move_count;

    int n_checks = 0;
    int n_bad    = 0;

    robot_cmd_scheduler #(
        .FRONT_CYCLES  (8),
        .TURN_CYCLES   (4),
        .REMOVE_CYCLES (12),
        .MAX_TURNS     (4),
        .MAX_REMOVES   (3),
        .IDLE_LIMIT    (16),
        .CNT_W         (16)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .front      (front),
        .turn       (turn),
        .remove     (remove),
        .step       (step),
        .motor_fwd  (motor_fwd),
        .motor_rot  (motor_rot),
        .brush_on   (brush_on),
        .busy       (busy),
        .done       (done),
        .fault      (fault),
        .fault_code (fault_code),
        .move_count (move_count)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    task automatic apply_rst();
        @(negedge clock);
        reset  = 1'b0;
        front  = 1'b0;
        turn   = 1'b0;
        remove = 1'b0;
        @(negedge clock);
    endtask

    task automatic release_rst(input logic f, input logic t, input logic r);
        @(negedge clock);
        front  = f;
        turn   = t;
        remove = r;
        reset  = 1'b1;
    endtask

    // Runs one accepted command of n cycles: actuator on for n cycles,
    // step in cycle n+1, back in SAMPLE (no step, not busy) in cycle n+2.
    task automatic run_cmd(input string tag, input logic [2:0] act, input int n);
        int good = 0;
        for (int i = 1; i <= n + 2; i++) begin
            logic [2:0] exp_act;
            @(posedge clock);
            #1;
            exp_act = (i <= n) ? act : 3'b000;
            if (({motor_fwd, motor_rot, brush_on} === exp_act) &&
                (step === (i == n + 1)) && (busy === (i <= n + 1)))
                good++;
        end
        chk(tag, 32'(good), 32'(n + 2));
    endtask

    initial begin
        int cnt;
        int good;
        reset  = 1'b0;
        front  = 1'b0;
        turn   = 1'b0;
        remove = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_act",   32'({motor_fwd, motor_rot, brush_on}), 32'd0);
        chk("rst_step",  32'(step), 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_flags", 32'({done, fault}), 32'd0);
        chk("rst_code",  32'(fault_code), 32'd0);
        chk("rst_count", 32'(move_count), 32'd0);

        // Front held high: 8 drive cycles, step, 10-cycle period.
        release_rst(1'b1, 1'b0, 1'b0);
        run_cmd("front_1", 3'b100, 8);
        chk("front_count", 32'(move_count), 32'd1);

        // Four turns accepted, the fifth faults with spin code.
        front = 1'b0;
        turn  = 1'b1;
        for (int k = 0; k < 4; k++) run_cmd("turn_run", 3'b010, 4);
        @(posedge clock);
        #1;
        chk("spin_fault", 32'(fault), 32'd1);
        chk("spin_code",  32'(fault_code), 32'd1);
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            if (step !== 1'b0 || {motor_fwd, motor_rot, brush_on} !== 3'b000 || busy !== 1'b0)
                cnt++;
            @(posedge clock);
            #1;
        end
        chk("spin_quiet", 32'(cnt), 32'd0);
        chk("spin_count", 32'(move_count), 32'd1);

        // Remove x3, front, remove x3 fine; a 4th consecutive remove faults.
        apply_rst();
        chk("rst2_fault", 32'(fault), 32'd0);
        release_rst(1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) run_cmd("rem_a", 3'b001, 12);
        remove = 1'b0;
        front  = 1'b1;
        run_cmd("front_mid", 3'b100, 8);
        chk("mid_count", 32'(move_count), 32'd1);
        front  = 1'b0;
        remove = 1'b1;
        for (int k = 0; k < 3; k++) run_cmd("rem_b", 3'b001, 12);
        chk("rem_no_fault", 32'(fault), 32'd0);
        @(posedge clock);
        #1;
        chk("trash_fault", 32'(fault), 32'd1);
        chk("trash_code",  32'(fault_code), 32'd2);

        // Two command bits at once: command fault, nothing ever actuated.
        apply_rst();
        release_rst(1'b1, 1'b1, 1'b0);
        #1;
        chk("multi_step", 32'(step), 32'd0);
        cnt = 0;
        @(posedge clock);
        #1;
        chk("multi_fault", 32'(fault), 32'd1);
        chk("multi_code",  32'(fault_code), 32'd3);
        for (int k = 0; k < 6; k++) begin
            if ({motor_fwd, motor_rot, brush_on} !== 3'b000) cnt++;
            @(posedge clock);
            #1;
        end
        chk("multi_no_act", 32'(cnt), 32'd0);

        // All-zero samples: 16 consecutive steps, silent limit sample, done.
        apply_rst();
        release_rst(1'b0, 1'b0, 1'b0);
        #1;
        good = 0;
        cnt  = 0;
        for (int k = 0; k <= 20; k++) begin
            if (step === 1'b1) cnt++;
            if ((step === (k < 16)) && (done === (k >= 17))) good++;
            @(posedge clock);
            #1;
        end
        chk("idle_pattern", 32'(good), 32'd21);
        chk("idle_steps",   32'(cnt), 32'd16);
        chk("idle_done",    32'(done), 32'd1);

        // Reset mid remove drops the brush at once; next command runs normally.
        apply_rst();
        release_rst(1'b0, 1'b0, 1'b1);
        repeat (5) @(posedge clock);
        #1;
        chk("mid_brush_on", 32'(brush_on), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_brush_off", 32'(brush_on), 32'd0);
        chk("mid_busy",      32'(busy), 32'd0);
        chk("mid_flags",     32'({done, fault, fault_code}), 32'd0);
        release_rst(1'b0, 1'b0, 1'b1);
        run_cmd("rem_after_rst", 3'b001, 12);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
